// File: rtl/frame_buffer_arbiter_pkg.sv
// Shared frame-buffer definitions: playfield geometry, the clear colour and
// a range helper used by the arbiter.
package frame_buffer_arbiter_pkg;

  localparam int BLOCKS_WIDE = 8;
  localparam int BLOCKS_HIGH = 4;
  localparam logic [7:0] BLACK = 8'h00;

  // Only addresses inside the populated block area may be written.
  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/frame_buffer_arbiter.sv
// Single-port frame-buffer BRAM arbiter: display reads beat screen-clear
// writes, which beat game-logic writes.
module frame_buffer_arbiter
  import frame_buffer_arbiter_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int DEPTH  = BLOCKS_WIDE * BLOCKS_HIGH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              wr_err,
  input  logic              clear_start,
  output logic              busy,
  output logic              clear_done,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  output logic              bram_we,
  input  logic [DATA_W-1:0] bram_dout
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [0:0]        state;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] disp_hold;
  logic              disp_grant;
  logic              clr_grant;
  logic              wr_grant;
  logic              wr_in_range;

  // Grants are gated by rst_n so the BRAM port is forced idle during reset.
  assign disp_grant  = rst_n && disp_req;
  assign clr_grant   = rst_n && !disp_req && (state == CLEAR);
  assign wr_grant    = rst_n && !disp_req && (state == IDLE) && wr_req;
  assign wr_in_range = addr_in_range(32'(wr_addr), DEPTH);

  assign wr_ack  = wr_grant;
  assign wr_err  = wr_grant && !wr_in_range;
  assign bram_we = clr_grant || (wr_grant && wr_in_range);
  assign busy    = (state == CLEAR);

  always_comb begin
    bram_addr = '0;
    bram_din  = '0;
    if (disp_grant) begin
      bram_addr = disp_addr;
    end else if (clr_grant) begin
      bram_addr = clr_addr;
      bram_din  = DATA_W'(BLACK);
    end else if (wr_grant) begin
      bram_addr = wr_addr;
      bram_din  = wr_data;
    end
  end

  // The clear pointer only advances on cycles its write actually wins the port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      clr_addr   <= '0;
      clear_done <= 1'b0;
    end else begin
      clear_done <= 1'b0;
      case (state)
        IDLE: begin
          if (clear_start) begin
            state    <= CLEAR;
            clr_addr <= '0;
          end
        end
        CLEAR: begin
          if (clr_grant) begin
            if (clr_addr == LAST_ADDR) begin
              state      <= IDLE;
              clr_addr   <= '0;
              clear_done <= 1'b1;
            end else begin
              clr_addr <= clr_addr + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_valid <= 1'b0;
      disp_hold  <= '0;
    end else begin
      disp_valid <= disp_grant;
      if (disp_valid) begin
        disp_hold <= bram_dout;
      end
    end
  end

  // Read data is passed straight through on its valid cycle, then held.
  assign disp_data = disp_valid ? bram_dout : disp_hold;

endmodule

// File: doc/frame_buffer_arbiter.md
FRAME_BUFFER_ARBITER -- requirements
Module: frame_buffer_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, width of the frame-buffer BRAM address.
REQ-002 SHALL have parameter DATA_W, default 8, width of one RGB pixel word.
REQ-003 SHALL have parameter DEPTH, default `BLOCKS_WIDE*`BLOCKS_HIGH, number of valid block entries.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port disp_req  input  1  display read request, one per cycle.
REQ-007 SHALL have port disp_addr  input  ADDR_W  display read address.
REQ-008 SHALL have port disp_data  output  DATA_W  display read data.
REQ-009 SHALL have port disp_valid  output  1  disp_data valid this cycle.
REQ-010 SHALL have port wr_req  input  1  game-logic write request, held until wr_ack.
REQ-011 SHALL have port wr_addr  input  ADDR_W  write address.
REQ-012 SHALL have port wr_data  input  DATA_W  write data.
REQ-013 SHALL have port wr_ack  output  1  one-cycle pulse, write accepted.
REQ-014 SHALL have port wr_err  output  1  one-cycle pulse with wr_ack, address out of range.
REQ-015 SHALL have port clear_start  input  1  pulse, start screen clear.
REQ-016 SHALL have port busy  output  1  clear in progress.
REQ-017 SHALL have port clear_done  output  1  one-cycle pulse, clear finished.
REQ-018 SHALL have ports bram_addr (output ADDR_W), bram_din (output DATA_W), bram_we (output 1), bram_dout (input DATA_W): single-port BRAM, read latency 1 cycle.

Function
REQ-019 SHALL use states IDLE and CLEAR; IDLE->CLEAR on clear_start, CLEAR->IDLE after address DEPTH-1 is written.
REQ-020 SHALL grant the BRAM each cycle by fixed priority: disp_req > clear write (CLEAR) > wr_req (IDLE only).
REQ-021 SHALL, on display grant, drive bram_addr=disp_addr, bram_we=0, and assert disp_valid with disp_data=bram_dout exactly 1 cycle later.
REQ-022 SHALL hold disp_data at last value when disp_valid=0.
REQ-023 SHALL, on write grant with wr_addr<DEPTH, drive bram_we=1, bram_addr=wr_addr, bram_din=wr_data and pulse wr_ack the same cycle.
REQ-024 SHALL, on write grant with wr_addr>=DEPTH, keep bram_we=0 and pulse wr_ack and wr_err together.
REQ-025 SHALL not assert wr_ack while busy=1; pending wr_req is served first free cycle after CLEAR exits.
REQ-026 SHALL in CLEAR write `BLACK to a clear counter address starting at 0, incrementing only on cycles the clear write is granted (stalls while disp_req=1).
REQ-027 SHALL pulse clear_done the cycle after the DEPTH-1 write and deassert busy that same cycle.
REQ-028 SHALL ignore clear_start while busy=1; clear_start and wr_req in the same IDLE cycle: the write is served that cycle, CLEAR entered next cycle.
REQ-029 SHALL drive bram_we=0 on every cycle with no write grant; at most one BRAM access per cycle.

Reset
REQ-030 SHALL on rst_n=0 asynchronously force IDLE, clear counter 0, busy=0, clear_done=0, wr_ack=0, wr_err=0, disp_valid=0, disp_data=0, bram_we=0, bram_addr=0, bram_din=0.
REQ-031 SHALL abort a CLEAR in progress on reset with no clear_done pulse; partially cleared contents left as is.

Structure
REQ-032 SHALL take `BLACK, `BLOCKS_WIDE, `BLOCKS_HIGH from the shared definitions.vh; state encodings local.
REQ-033 SHALL be one flat module; the BRAM is instantiated outside, no sub-modules.

Verification
REQ-034 Display only: disp_req=1, disp_addr=5, BRAM[5]=8'hE0 -> disp_valid=1, disp_data=8'hE0 next cycle, bram_we=0.
REQ-035 Contention: disp_req=1 and wr_req=1 (addr 3, data 8'h1C) for 2 cycles then disp_req=0 -> wr_ack on cycle 3 only, BRAM[3]=8'h1C.
REQ-036 Out-of-range: wr_req addr=DEPTH -> wr_ack=wr_err=1 one cycle, bram_we never 1, memory unchanged.
REQ-037 Clear: BRAM filled 8'hFF, clear_start, disp_req toggling every other cycle -> exactly DEPTH writes of `BLACK, clear_done once, busy high throughout, wr_req held meanwhile acked only after clear_done.
REQ-038 Reset mid-clear: rst_n=0 after 10 clear writes -> busy=0 immediately, no clear_done, BRAM[0..9]=`BLACK, BRAM[10]=8'hFF.
